// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master (CPOL=0, CPHA=0, MSB first).
// Generates SCLK/CS_N/MOSI from CLK, captures MISO on every SCLK rise and
// returns the received word with a one-cycle DONE pulse. All outputs are
// registered; one word is moved per accepted START.
module spi_master_ctrl #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              SCLK,
  output logic              CS_N,
  output logic              MOSI,
  input  logic              MISO
);

  // A one-cycle half period still needs a 1-bit counter.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_q,   state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  // Set once the last bit's high phase ends: the following LOW phase is the
  // CS_N hold phase rather than a normal bit low phase.
  logic                hold_q,    hold_d;
  logic [DATA_W-1:0]   tx_q,      tx_d;
  logic [DATA_W-1:0]   rx_q,      rx_d;
  logic                sclk_q,    sclk_d;
  logic                cs_n_q,    cs_n_d;
  logic                mosi_q,    mosi_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;

  logic div_last_s;
  logic bit_last_s;

  assign div_last_s = (div_cnt_q == DIV_LAST);
  assign bit_last_s = (bit_cnt_q == BIT_LAST);

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      hold_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Next-state logic: each timed phase lasts CLK_DIV cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_SETUP;
        else       state_d = ST_IDLE;
      end
      ST_SETUP: begin
        if (div_last_s) state_d = ST_HIGH;
        else            state_d = ST_SETUP;
      end
      ST_HIGH: begin
        if (div_last_s) state_d = ST_LOW;
        else            state_d = ST_HIGH;
      end
      ST_LOW: begin
        if (div_last_s) state_d = hold_q ? ST_DONE : ST_HIGH;
        else            state_d = ST_LOW;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; SCLK edges are launched at phase ends.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = done_q;
    rx_data_d = rx_data_q;
    case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        if (START) begin
          tx_d      = TX_DATA;
          rx_d      = '0;
          bit_cnt_d = '0;
          hold_d    = 1'b0;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          mosi_d    = TX_DATA[DATA_W-1];
        end else begin
          mosi_d    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (div_last_s) begin
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          rx_d      = {rx_q[DATA_W-2:0], MISO};
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (div_last_s) begin
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          if (!bit_last_s) begin
            // Rotate so the next bit to send is always at tx_q[DATA_W-2].
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_d      = {tx_q[DATA_W-2:0], tx_q[DATA_W-1]};
            mosi_d    = tx_q[DATA_W-2];
          end else begin
            hold_d    = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      ST_LOW: begin
        if (div_last_s) begin
          div_cnt_d = '0;
          if (!hold_q) begin
            sclk_d    = 1'b1;
            rx_d      = {rx_q[DATA_W-2:0], MISO};
          end else begin
            hold_d    = 1'b0;
            cs_n_d    = 1'b1;
            mosi_d    = 1'b0;
            rx_data_d = rx_q;
            done_d    = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
      end
      default: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        hold_d    = 1'b0;
        sclk_d    = 1'b0;
        cs_n_d    = 1'b1;
        mosi_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign RX_DATA = rx_data_q;
  assign SCLK    = sclk_q;
  assign CS_N    = cs_n_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl: two instances (8-bit/div 2 and 16-bit/div 1).
// Stimulus pushes expected words into queues; monitors pop and compare on DONE.
module tb_spi_master_ctrl;

  localparam int WA = 8;
  localparam int DA = 2;
  localparam int WB = 16;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          start_a = 1'b0;
  logic [WA-1:0] tx_a    = '0;
  logic          busy_a, done_a, sclk_a, cs_n_a, mosi_a, miso_a;
  logic [WA-1:0] rx_a;

  logic          start_b = 1'b0;
  logic [WB-1:0] tx_b    = '0;
  logic          busy_b, done_b, sclk_b, cs_n_b, mosi_b, miso_b;
  logic [WB-1:0] rx_b;

  // Slave model for instance A: shifts slave_word out MSB first, changing on SCLK fall.
  logic          miso_mode  = 1'b0;
  logic [WA-1:0] slave_word = '0;
  int            sl_bit     = 0;
  logic          miso_sl;

  typedef struct { logic [WA-1:0] tx; logic [WA-1:0] rx; } exp_a_t;
  exp_a_t        q_a[$];
  logic [WB-1:0] q_b[$];

  int checks = 0;
  int failures = 0;
  int n_push_a = 0;
  int a_n_done = 0;

  spi_master_ctrl #(.DATA_W(WA), .CLK_DIV(DA)) dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .TX_DATA(tx_a), .BUSY(busy_a),
    .DONE(done_a), .RX_DATA(rx_a), .SCLK(sclk_a), .CS_N(cs_n_a),
    .MOSI(mosi_a), .MISO(miso_a)
  );

  spi_master_ctrl #(.DATA_W(WB), .CLK_DIV(DB)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .TX_DATA(tx_b), .BUSY(busy_b),
    .DONE(done_b), .RX_DATA(rx_b), .SCLK(sclk_b), .CS_N(cs_n_b),
    .MOSI(mosi_b), .MISO(miso_b)
  );

  always #5 clk = ~clk;

  always @(negedge sclk_a or posedge cs_n_a) begin
    if (cs_n_a) sl_bit = 0;
    else        sl_bit = sl_bit + 1;
  end

  always_comb begin
    if (sl_bit < WA) miso_sl = slave_word[WA-1-sl_bit];
    else             miso_sl = 1'b0;
  end

  assign miso_a = miso_mode ? miso_sl : mosi_a;
  assign miso_b = mosi_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor for instance A ----------------
  logic          a_prev_sclk = 1'b0, a_prev_cs = 1'b1, a_prev_mosi = 1'b0;
  logic          a_prev_done = 1'b0, a_prev_busy = 1'b0;
  int            a_rises = 0, a_cs_low = 0, a_gap = 0, a_last_gap = 0;
  int            a_blow = 0, a_last_blow = 0;
  logic [WA-1:0] a_mosi_word = '0, a_rx_hold = '0;
  exp_a_t        ea;

  always @(negedge clk) begin
    if (rst) begin
      a_rises = 0; a_cs_low = 0; a_mosi_word = '0; a_rx_hold = '0;
    end else begin
      if (a_prev_done) chk("a_done_width", {31'd0, done_a}, 32'd0);
      if (mosi_a !== a_prev_mosi)
        chk("a_mosi_edge", {31'd0, (a_prev_sclk && !sclk_a) || (cs_n_a != a_prev_cs)}, 32'd1);
      if (!cs_n_a) a_cs_low++;
      if (sclk_a && !a_prev_sclk) begin
        a_mosi_word = {a_mosi_word[WA-2:0], mosi_a};
        a_rises++;
      end
      if (cs_n_a) a_gap++;
      else if (a_prev_cs) begin a_last_gap = a_gap; a_gap = 0; end
      if (!busy_a) a_blow++;
      else if (!a_prev_busy) begin a_last_blow = a_blow; a_blow = 0; end
      if (done_a) begin
        a_n_done++;
        chk("a_done_expected", {31'd0, q_a.size() > 0}, 32'd1);
        if (q_a.size() > 0) begin
          ea = q_a.pop_front();
          chk("a_rx_data", rx_a, ea.rx);
          chk("a_mosi_seq", a_mosi_word, ea.tx);
          chk("a_sclk_rises", a_rises, WA);
          chk("a_cs_low_cycles", a_cs_low, DA * (2 * WA + 1));
          chk("a_busy_in_done", {31'd0, busy_a}, 32'd1);
        end
        a_rises = 0; a_cs_low = 0; a_mosi_word = '0;
        a_rx_hold = rx_a;
      end else begin
        chk("a_rx_hold", rx_a, a_rx_hold);
      end
    end
    a_prev_sclk = sclk_a; a_prev_cs = cs_n_a; a_prev_mosi = mosi_a;
    a_prev_done = done_a; a_prev_busy = busy_a;
  end

  // ---------------- monitor for instance B ----------------
  logic          b_prev_sclk = 1'b0;
  int            b_rises = 0, b_cs_low = 0;
  logic [WB-1:0] b_mosi_word = '0, eb;

  always @(negedge clk) begin
    if (rst) begin
      b_rises = 0; b_cs_low = 0; b_mosi_word = '0;
    end else begin
      if (!cs_n_b) b_cs_low++;
      if (sclk_b && !b_prev_sclk) begin
        b_mosi_word = {b_mosi_word[WB-2:0], mosi_b};
        b_rises++;
      end
      if (done_b) begin
        chk("b_done_expected", {31'd0, q_b.size() > 0}, 32'd1);
        if (q_b.size() > 0) begin
          eb = q_b.pop_front();
          chk("b_rx_data", rx_b, eb);
          chk("b_mosi_seq", b_mosi_word, eb);
          chk("b_sclk_rises", b_rises, WB);
          chk("b_cs_low_cycles", b_cs_low, DB * (2 * WB + 1));
        end
        b_rises = 0; b_cs_low = 0; b_mosi_word = '0;
      end
    end
    b_prev_sclk = sclk_b;
  end

  // ---------------- stimulus ----------------
  task automatic wait_busy_a(input logic val, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (busy_a === val) seen = 1'b1;
    end
    if (!seen) chk(name, {31'd0, busy_a}, {31'd0, val});
  endtask

  task automatic wait_busy_b(input logic val, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (busy_b === val) seen = 1'b1;
    end
    if (!seen) chk(name, {31'd0, busy_b}, {31'd0, val});
  endtask

  task automatic xfer_a(input logic [WA-1:0] tx, input logic mode, input logic [WA-1:0] sw,
                        input bit disturb);
    exp_a_t e;
    wait_busy_a(1'b0, 200, "a_wait_idle");
    @(negedge clk);
    miso_mode = mode; slave_word = sw; tx_a = tx; start_a = 1'b1;
    e.tx = tx; e.rx = mode ? sw : tx;
    q_a.push_back(e); n_push_a++;
    @(negedge clk); start_a = 1'b0;
    if (disturb) begin
      repeat (6) @(negedge clk);
      tx_a = 8'h3C; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (9) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk); start_a = 1'b0; tx_a = tx;
    end
    wait_busy_a(1'b0, 200, "a_wait_complete");
  endtask

  task automatic xfer_b(input logic [WB-1:0] tx);
    wait_busy_b(1'b0, 200, "b_wait_idle");
    @(negedge clk);
    tx_b = tx; start_b = 1'b1; q_b.push_back(tx);
    @(negedge clk); start_b = 1'b0;
    wait_busy_b(1'b0, 200, "b_wait_complete");
  endtask

  initial begin
    int   rises;
    logic prev;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    // Reset state of both instances.
    chk("rst_a_sclk", {31'd0, sclk_a}, 32'd0);
    chk("rst_a_cs_n", {31'd0, cs_n_a}, 32'd1);
    chk("rst_a_mosi", {31'd0, mosi_a}, 32'd0);
    chk("rst_a_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_a_done", {31'd0, done_a}, 32'd0);
    chk("rst_a_rx", rx_a, 32'd0);
    chk("rst_b_sclk", {31'd0, sclk_b}, 32'd0);
    chk("rst_b_cs_n", {31'd0, cs_n_b}, 32'd1);
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
    chk("rst_b_rx", rx_b, 32'd0);

    // Loopback, constant MISO and a disturbed transfer.
    xfer_a(8'hA5, 1'b0, 8'h00, 1'b0);
    xfer_a(8'h00, 1'b1, 8'hFF, 1'b0);
    xfer_a(8'hFF, 1'b1, 8'h00, 1'b0);
    xfer_a(8'h96, 1'b0, 8'h00, 1'b1);

    // Random words with random MISO source.
    repeat (8) xfer_a(WA'($urandom), 1'($urandom), WA'($urandom), 1'b0);

    // Reset abort after the third SCLK rise.
    wait_busy_a(1'b0, 200, "a_wait_idle");
    @(negedge clk);
    miso_mode = 1'b0; tx_a = WA'($urandom); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    rises = 0; prev = sclk_a;
    for (int i = 0; i < 200 && rises < 3; i++) begin
      @(posedge clk); #1;
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
    end
    chk("abort_rises", rises, 3);
    #1 rst = 1'b1;
    #1;
    chk("abort_cs_n", {31'd0, cs_n_a}, 32'd1);
    chk("abort_sclk", {31'd0, sclk_a}, 32'd0);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_done", {31'd0, done_a}, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    xfer_a(8'h5A, 1'b0, 8'h00, 1'b0);

    // START held high: back-to-back transfers.
    miso_mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_a_t e;
      wait_busy_a(1'b0, 200, "b2b_wait_idle");
      @(negedge clk);
      tx_a = WA'($urandom); start_a = 1'b1;
      e.tx = tx_a; e.rx = tx_a;
      q_a.push_back(e); n_push_a++;
      wait_busy_a(1'b1, 5, "b2b_accept");
      @(negedge clk); #1;
      if (k > 0) begin
        chk("b2b_cs_gap", a_last_gap, 2);
        chk("b2b_busy_low", a_last_blow, 1);
      end
    end
    start_a = 1'b0;
    wait_busy_a(1'b0, 200, "b2b_wait_complete");

    // Fastest SCLK, 16-bit word.
    xfer_b(16'h8001);
    repeat (3) xfer_b(WB'($urandom));

    repeat (5) @(negedge clk);
    chk("a_pending", q_a.size(), 32'd0);
    chk("b_pending", q_b.size(), 32'd0);
    chk("a_done_count", a_n_done, n_push_a);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
